// File: rtl/stepper_move_ctrl.sv
// Motion sequencer for a full-step bipolar driver: homing against a limit switch,
// absolute moves with a linear trapezoidal step-period ramp, paced step strobes.
module stepper_move_ctrl #(
  parameter int P_POS_MAX   = 200,
  parameter int P_DIV_W     = 16,
  parameter int P_START_DIV = 1000,
  parameter int P_MIN_DIV   = 250,
  parameter int P_RAMP_DEC  = 50,
  parameter int P_SETTLE    = 100
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [7:0] i_cmd_target,
  input  logic       i_home,
  input  logic       i_home_sw,
  input  logic       i_abort,
  output logic       o_step,
  output logic       o_dir,
  output logic [7:0] o_pos,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOME   = 2'd1;
  localparam logic [1:0] S_MOVE   = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  localparam int                 HC_W      = $clog2(2*P_POS_MAX+1);
  localparam logic [HC_W-1:0]    HOME_MAX  = HC_W'(2*P_POS_MAX);
  localparam logic [HC_W-1:0]    HC_ONE    = HC_W'(1);
  localparam logic [7:0]         POS_MAX   = 8'(P_POS_MAX);
  localparam logic [P_DIV_W-1:0] START_DIV = P_DIV_W'(P_START_DIV);
  localparam logic [P_DIV_W-1:0] MIN_DIV   = P_DIV_W'(P_MIN_DIV);
  localparam logic [P_DIV_W-1:0] SETTLE    = P_DIV_W'(P_SETTLE);
  localparam logic [P_DIV_W-1:0] ONE       = P_DIV_W'(1);
  localparam logic [P_DIV_W:0]   RAMP_DEC  = (P_DIV_W+1)'(P_RAMP_DEC);

  logic [1:0]         state_q, state_d;
  logic [7:0]         pos_q, pos_d, tgt_q, tgt_d;
  logic               dir_q, dir_d, step_q, step_d, done_q, done_d;
  logic               err_q, err_d, homed_q, homed_d;
  logic [P_DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, acc_q, acc_d;
  logic [HC_W-1:0]    hcnt_q, hcnt_d;
  logic               sw_meta_q, sw_sync_q;

  logic               tick;
  logic [7:0]         pos_nxt, rem;
  logic [P_DIV_W:0]   div_up, div_dn_lim;
  logic [P_DIV_W-1:0] div_nxt, acc_nxt;

  // Ramp decision for the step being issued, based on distance left after it.
  always_comb begin
    tick       = (cnt_q == ONE);
    pos_nxt    = dir_q ? pos_q + 8'd1 : pos_q - 8'd1;
    rem        = dir_q ? tgt_q - pos_nxt : pos_nxt - tgt_q;
    div_up     = {1'b0, div_q} + RAMP_DEC;
    div_dn_lim = {1'b0, MIN_DIV} + RAMP_DEC;
    div_nxt    = div_q;
    acc_nxt    = acc_q;
    if (P_DIV_W'(rem) <= acc_q) begin
      div_nxt = (div_up > {1'b0, START_DIV}) ? START_DIV : div_up[P_DIV_W-1:0];
      if (acc_q != '0) acc_nxt = acc_q - ONE;
    end else if (div_q > MIN_DIV) begin
      div_nxt = ({1'b0, div_q} < div_dn_lim) ? MIN_DIV : div_q - RAMP_DEC[P_DIV_W-1:0];
      if (acc_q != '1) acc_nxt = acc_q + ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    tgt_d   = tgt_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    homed_d = homed_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    acc_d   = acc_q;
    hcnt_d  = hcnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_home) begin
          state_d = S_HOME;
          dir_d   = 1'b0;
          cnt_d   = START_DIV;
          hcnt_d  = '0;
        end else if (i_cmd_valid) begin
          if (!homed_q || i_cmd_target > POS_MAX) begin
            err_d = 1'b1;
          end else if (i_cmd_target == pos_q) begin
            done_d = 1'b1;
          end else begin
            state_d = S_MOVE;
            dir_d   = (i_cmd_target > pos_q);
            tgt_d   = i_cmd_target;
            cnt_d   = START_DIV;
            div_d   = START_DIV;
            acc_d   = '0;
          end
        end
      end
      S_HOME: begin
        if (i_abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          homed_d = 1'b0;
        end else if (sw_sync_q) begin
          state_d = S_SETTLE;
          pos_d   = '0;
          homed_d = 1'b1;
          cnt_d   = SETTLE;
        end else if (hcnt_q == HOME_MAX) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          homed_d = 1'b0;
        end else if (tick) begin
          step_d = 1'b1;
          cnt_d  = START_DIV;
          hcnt_d = hcnt_q + HC_ONE;
          if (pos_q != '0) pos_d = pos_q - 8'd1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_MOVE: begin
        if (i_abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (tick) begin
          step_d = 1'b1;
          pos_d  = pos_nxt;
          div_d  = div_nxt;
          acc_d  = acc_nxt;
          cnt_d  = div_nxt;
          if (pos_nxt == tgt_q) begin
            state_d = S_SETTLE;
            cnt_d   = SETTLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        if (i_abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (tick) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pos_q     <= '0;
      tgt_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      homed_q   <= 1'b0;
      cnt_q     <= '0;
      div_q     <= START_DIV;
      acc_q     <= '0;
      hcnt_q    <= '0;
      sw_meta_q <= 1'b0;
      sw_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      tgt_q     <= tgt_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      done_q    <= done_d;
      err_q     <= err_d;
      homed_q   <= homed_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      acc_q     <= acc_d;
      hcnt_q    <= hcnt_d;
      sw_meta_q <= i_home_sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_busy      = (state_q != S_IDLE);
  assign o_step      = step_q;
  assign o_dir       = dir_q;
  assign o_pos       = pos_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Scoreboard bench: a timeline model predicts every step/done/err event with its
// absolute clock edge; a monitor pops and compares whenever the DUT pulses one.
module tb_stepper_move_ctrl;
  localparam int POS_MAX = 200;
  localparam int DIV_W   = 16;
  localparam int START   = 40;
  localparam int MIN_D   = 10;
  localparam int DEC     = 2;
  localparam int SETTLE  = 8;
  localparam int NEVER   = 32'h3fff_ffff;
  localparam logic [2:0] K_STEP = 3'b001;
  localparam logic [2:0] K_DONE = 3'b010;
  localparam logic [2:0] K_ERR  = 3'b100;

  typedef struct {
    logic [2:0] kind;
    int         t;
    int         pos;
    logic       dir;
  } ev_t;

  logic       clk = 1'b0, rst = 1'b0;
  logic       cmd_valid = 1'b0, home = 1'b0, home_sw = 1'b0, abort_i = 1'b0;
  logic [7:0] tgt = '0;
  logic       cmd_ready, step, dir, busy, done, err;
  logic [7:0] pos;

  int  cyc = 0, n_cmp = 0, n_bad = 0;
  ev_t exp_q[$];
  ev_t tmp_q[$];
  int  m_pos;
  bit  m_homed, m_dir;

  stepper_move_ctrl #(
    .P_POS_MAX(POS_MAX), .P_DIV_W(DIV_W), .P_START_DIV(START),
    .P_MIN_DIV(MIN_D), .P_RAMP_DEC(DEC), .P_SETTLE(SETTLE)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_target(tgt), .i_home(home), .i_home_sw(home_sw), .i_abort(abort_i),
    .o_step(step), .o_dir(dir), .o_pos(pos), .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ev_t e;
    if (!rst && (step || done || err)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: edge=%0d got step/done/err=%b%b%b pos=%0d, required no event",
                 cyc, step, done, err, pos);
      end else begin
        e = exp_q.pop_front();
        if ({err, done, step} != e.kind || cyc != e.t || int'(pos) != e.pos ||
            dir != e.dir || busy != (e.kind == K_STEP) || cmd_ready == busy) begin
          n_bad++;
          $display("FAIL event: got err/done/step=%b edge=%0d pos=%0d dir=%b busy=%b ready=%b, required %b edge=%0d pos=%0d dir=%b busy=%b",
                   {err, done, step}, cyc, pos, dir, busy, cmd_ready,
                   e.kind, e.t, e.pos, e.dir, (e.kind == K_STEP));
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic wait_cyc(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add(input logic [2:0] k, input int t, input int p, input logic d);
    ev_t e;
    e.kind = k; e.t = t; e.pos = p; e.dir = d;
    tmp_q.push_back(e);
  endtask

  // Move accepted at edge A; abort sampled at edge ab (NEVER if none).
  task automatic predict_move(input int A, input int target, input int ab,
                              output int p_o, output bit d_o);
    int p, t, div, acc, rem;
    bit d;
    tmp_q.delete();
    p = m_pos; d = m_dir;
    if (!m_homed || target > POS_MAX) add(K_ERR, A, p, d);
    else if (target == p) add(K_DONE, A, p, d);
    else begin
      d = (target > p); div = START; acc = 0; t = A;
      while (p != target && t + div < ab) begin
        t += div;
        p += d ? 1 : -1;
        add(K_STEP, t, p, d);
        rem = d ? target - p : p - target;
        if (rem <= acc) begin
          div = (div + DEC > START) ? START : div + DEC;
          if (acc > 0) acc--;
        end else if (div > MIN_D) begin
          div = (div - DEC < MIN_D) ? MIN_D : div - DEC;
          acc++;
        end
      end
      if (p != target || ab <= t + SETTLE) add(K_ERR, ab, p, d);
      else add(K_DONE, t + SETTLE, p, d);
    end
    p_o = p; d_o = d;
  endtask

  // Homing accepted at edge A; switch driven high just after edge X; abort at edge ab.
  task automatic predict_home(input int A, input int X, input int ab,
                              output int p_o, output bit h_o);
    int p, t, k, det, tn;
    tmp_q.delete();
    p = m_pos; t = A; k = 0; h_o = 1'b0;
    det = (X == NEVER) ? NEVER : ((X + 3 > A + 1) ? X + 3 : A + 1);
    forever begin
      tn = (k == 2*POS_MAX) ? t + 1 : t + START;
      if (ab <= det && ab <= tn) begin
        add(K_ERR, ab, p, 1'b0);
        break;
      end
      if (det <= tn) begin
        p = 0; h_o = 1'b1;
        if (ab <= det + SETTLE) add(K_ERR, ab, 0, 1'b0);
        else add(K_DONE, det + SETTLE, 0, 1'b0);
        break;
      end
      if (k == 2*POS_MAX) begin
        add(K_ERR, tn, p, 1'b0);
        break;
      end
      k++;
      p = (p > 0) ? p - 1 : 0;
      add(K_STEP, tn, p, 1'b0);
      t = tn;
    end
    p_o = p;
  endtask

  task automatic finish_op(input string name, input int p, input bit d);
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    check({name, "_ready"}, int'(cmd_ready), 1);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_pos"}, int'(pos), p);
    check({name, "_dir"}, int'(dir), int'(d));
    m_pos = p; m_dir = d;
  endtask

  // ab_step: abort the cycle after that step; ab_off: abort that many edges before done.
  task automatic do_move(input int target, input int ab_step, input int ab_off);
    int A, ab, p, fin;
    bit d;
    A = cyc + 1; ab = NEVER;
    if (ab_step > 0 || ab_off > 0) begin
      predict_move(A, target, NEVER, p, d);
      if (tmp_q.size() > 1 && tmp_q[tmp_q.size()-1].kind == K_DONE) begin
        if (ab_step > 0 && ab_step <= tmp_q.size() - 1) ab = tmp_q[ab_step-1].t + 2;
        else if (ab_off > 0) ab = tmp_q[tmp_q.size()-1].t - ab_off;
      end
    end
    predict_move(A, target, ab, p, d);
    fin = tmp_q[tmp_q.size()-1].t;
    foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
    cmd_valid = 1'b1; tgt = 8'(target);
    wait_cyc(A);
    cmd_valid = 1'b0;
    if (ab != NEVER) begin
      wait_cyc(ab - 1); abort_i = 1'b1;
      wait_cyc(ab);     abort_i = 1'b0;
    end
    wait_cyc(fin + 2);
    finish_op("move", p, d);
  endtask

  // sw_step: -1 never, 0 switch already high, j>0 switch rises the cycle after step j.
  task automatic do_home(input int sw_step, input int ab_step);
    int A, X, ab, p, fin;
    bit h;
    X = NEVER; ab = NEVER;
    if (sw_step == 0) begin
      home_sw = 1'b1; X = cyc;
      wait_cyc(cyc + 4);
    end
    A = cyc + 1;
    if (sw_step > 0 || ab_step > 0) begin
      predict_home(A, X, NEVER, p, h);
      if (sw_step > 0) X = tmp_q[sw_step-1].t + 1;
      else ab = tmp_q[ab_step-1].t + 2;
    end
    predict_home(A, X, ab, p, h);
    fin = tmp_q[tmp_q.size()-1].t;
    foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
    home = 1'b1;
    wait_cyc(A);
    home = 1'b0;
    if (X != NEVER && X >= A) begin
      wait_cyc(X); home_sw = 1'b1;
    end
    if (ab != NEVER) begin
      wait_cyc(ab - 1); abort_i = 1'b1;
      wait_cyc(ab);     abort_i = 1'b0;
    end
    wait_cyc(fin + 2);
    finish_op("home", p, 1'b0);
    m_homed = h;
    home_sw = 1'b0;
    wait_cyc(cyc + 3);
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_step"},  int'(step), 0);
    check({name, "_dir"},   int'(dir), 0);
    check({name, "_pos"},   int'(pos), 0);
    check({name, "_busy"},  int'(busy), 0);
    check({name, "_done"},  int'(done), 0);
    check({name, "_err"},   int'(err), 0);
    check({name, "_ready"}, int'(cmd_ready), 1);
  endtask

  initial begin
    int A, p, r;
    bit d;
    m_pos = 0; m_homed = 1'b0; m_dir = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst = 1'b0;
    wait_cyc(cyc + 2);

    do_move(10, 0, 0);
    do_home(5, 0);
    do_move(20, 0, 0);
    do_move(20, 0, 0);
    do_move(0, 0, 0);
    do_move(200, 0, 0);
    do_move(201, 0, 0);
    do_move(0, 0, 0);
    do_move(50, 5, 0);
    do_move(0, 0, 0);
    do_home(0, 0);
    do_move(30, 0, 0);
    do_move(25, 0, 3);
    do_home(-1, 3);
    do_move(10, 0, 0);
    do_home(-1, 0);
    do_move(10, 0, 0);
    do_home(3, 0);

    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       do_home($urandom_range(0, 6), 0);
        1:       do_home(-1, 2);
        2:       do_move($urandom_range(0, 215), $urandom_range(1, 6), 0);
        3:       do_move($urandom_range(0, 215), 0, $urandom_range(1, SETTLE - 1));
        default: do_move($urandom_range(0, 215), 0, 0);
      endcase
    end

    // Reset in the middle of a move.
    do_home(1, 0);
    A = cyc + 1;
    predict_move(A, 150, NEVER, p, d);
    foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
    cmd_valid = 1'b1; tgt = 8'd150;
    wait_cyc(A);
    cmd_valid = 1'b0;
    wait_cyc(tmp_q[2].t + 3);
    rst = 1'b1;
    #1;
    check_reset_outs("midreset");
    exp_q.delete();
    m_pos = 0; m_homed = 1'b0; m_dir = 1'b0;
    wait_cyc(cyc + 2);
    rst = 1'b0;
    wait_cyc(cyc + 1);
    do_move(10, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
